// File: rtl/motor_drive_pwm.sv
// motor_drive_pwm
//   Turns the move/rotate requests from control_host into per-wheel direction
//   and PWM drive for the two-wheel chassis. Duty ramps one step per prescaler
//   tick toward its target. A wheel that has to reverse first ramps to zero in
//   its old direction. It then holds PWM low for a dead time before its
//   direction output flips.
//
// Parameters
//   PWM_BITS    PWM counter width, period = 2**PWM_BITS clocks
//   RAMP_DIV    clocks per duty step (>= 1)
//   DUTY_MAX    straight-line duty
//   DUTY_TURN   turn / arc inner-wheel duty
//   DEAD_CYCLES clocks of forced-low PWM before a direction change (>= 1)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                0 = ramp both wheels to a stop
//   move_sig[1:0]         [1]=forward, [0]=backward (both set = no move)
//   rotate_sig[1:0]       [1]=left, [0]=right (both set = no rotate)
//   left_dir/right_dir    wheel direction, 1 = forward
//   left_pwm/right_pwm    wheel PWM
//   settled               both wheels at target dir+duty, no dead time active
module motor_drive_pwm #(
    parameter int PWM_BITS    = 8,
    parameter int RAMP_DIV    = 1000,
    parameter int DUTY_MAX    = 200,
    parameter int DUTY_TURN   = 100,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] move_sig,
    input  logic [1:0] rotate_sig,
    output logic       left_dir,
    output logic       left_pwm,
    output logic       right_dir,
    output logic       right_pwm,
    output logic       settled
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } wheel_state_e;

    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DC_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [PWM_BITS-1:0] D_MAX     = PWM_BITS'(DUTY_MAX);
    localparam logic [PWM_BITS-1:0] D_TURN    = PWM_BITS'(DUTY_TURN);
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(RAMP_DIV - 1);
    localparam logic [DC_W-1:0]     DEAD_LOAD = DC_W'(DEAD_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic       en_q;
    logic [1:0] move_q;
    logic [1:0] rot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            move_q <= '0;
            rot_q  <= '0;
        end else begin
            en_q   <= enable;
            move_q <= move_sig;
            rot_q  <= rotate_sig;
        end
    end

    // ------------------------------------------------------------------
    // Target decode. Bit/element 0 = left wheel, 1 = right wheel.
    // ------------------------------------------------------------------
    logic                     fwd, bwd, lft, rgt;
    logic [1:0]               req_dir;
    logic [1:0]               tgt_dir;
    logic [1:0][PWM_BITS-1:0] tgt_duty;
    logic [1:0]               dir_w;
    logic [1:0]               pwm_w;
    logic [1:0]               ok_w;

    always_comb begin
        fwd      = (move_q == 2'b10);
        bwd      = (move_q == 2'b01);
        lft      = (rot_q == 2'b10);
        rgt      = (rot_q == 2'b01);
        tgt_duty = '0;
        req_dir  = dir_w;
        if (en_q) begin
            if (fwd || bwd) begin
                // Arc: the wheel on the inside of the turn runs at turn duty.
                req_dir     = {fwd, fwd};
                tgt_duty[0] = lft ? D_TURN : D_MAX;
                tgt_duty[1] = rgt ? D_TURN : D_MAX;
            end else if (lft) begin
                req_dir  = 2'b10;
                tgt_duty = {D_TURN, D_TURN};
            end else if (rgt) begin
                req_dir  = 2'b01;
                tgt_duty = {D_TURN, D_TURN};
            end
        end
        // A stopped target keeps the present direction, so stopping never
        // costs a dead time.
        for (int unsigned w = 0; w < 2; w++) begin
            tgt_dir[w] = (tgt_duty[w] == '0) ? dir_w[w] : req_dir[w];
        end
    end

    // ------------------------------------------------------------------
    // Ramp prescaler and shared PWM counter
    // ------------------------------------------------------------------
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                tick;
    logic                cnt_wrap;

    always_comb begin
        tick     = (pre_q == PRE_LAST);
        pre_d    = tick ? '0 : pre_q + 1'b1;
        cnt_wrap = (cnt_q == '1);
        cnt_d    = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-wheel ramp / dead-time FSM and PWM compare
    // ------------------------------------------------------------------
    for (genvar w = 0; w < 2; w++) begin : g_wheel
        wheel_state_e        state_q, state_d;
        logic                dir_q, dir_d;
        logic [PWM_BITS-1:0] duty_q, duty_d;
        logic [PWM_BITS-1:0] act_q, act_d;
        logic [DC_W-1:0]     dead_q, dead_d;

        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            duty_d  = duty_q;
            dead_d  = dead_q;
            // Compare value only changes on the period boundary.
            act_d   = cnt_wrap ? duty_q : act_q;
            case (state_q)
                ST_RUN: begin
                    if (tgt_dir[w] == dir_q) begin
                        if (tick) begin
                            if (duty_q < tgt_duty[w]) begin
                                duty_d = duty_q + 1'b1;
                            end else if (duty_q > tgt_duty[w]) begin
                                duty_d = duty_q - 1'b1;
                            end
                        end
                    end else if (duty_q != '0) begin
                        // Reversal pending: decelerate in the old direction.
                        if (tick) begin
                            duty_d = duty_q - 1'b1;
                        end
                    end else begin
                        state_d = ST_DEAD;
                        dead_d  = DEAD_LOAD;
                    end
                end
                ST_DEAD: begin
                    // Runs to completion; if the target reverted meanwhile,
                    // tgt_dir equals dir_q and nothing flips.
                    if (dead_q == '0) begin
                        dir_d   = tgt_dir[w];
                        state_d = ST_RUN;
                    end else begin
                        dead_d = dead_q - 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_RUN;
                dir_q   <= 1'b1;
                duty_q  <= '0;
                act_q   <= '0;
                dead_q  <= '0;
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
                duty_q  <= duty_d;
                act_q   <= act_d;
                dead_q  <= dead_d;
            end
        end

        assign dir_w[w] = dir_q;
        assign pwm_w[w] = (state_q == ST_RUN) && (cnt_q < act_q);
        assign ok_w[w]  = (state_q == ST_RUN) && (duty_q == tgt_duty[w])
                          && (dir_q == tgt_dir[w]);
    end

    // ------------------------------------------------------------------
    // Settled flag
    // ------------------------------------------------------------------
    logic settled_q, settled_d;

    always_comb begin
        settled_d = &ok_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settled_q <= 1'b1;
        end else begin
            settled_q <= settled_d;
        end
    end

    assign left_dir  = dir_w[0];
    assign left_pwm  = pwm_w[0];
    assign right_dir = dir_w[1];
    assign right_pwm = pwm_w[1];
    assign settled   = settled_q;

endmodule

// File: tb/tb_motor_drive_pwm.sv
module tb_motor_drive_pwm;

    localparam int PB    = 4;
    localparam int RD    = 2;
    localparam int DMAX  = 12;
    localparam int DTURN = 6;
    localparam int DC    = 4;
    localparam int PER   = 1 << PB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] move_sig = 2'b00;
    logic [1:0] rotate_sig = 2'b00;
    logic       left_dir, left_pwm, right_dir, right_pwm, settled;

    always #5 clk = ~clk;

    motor_drive_pwm #(
        .PWM_BITS   (PB),
        .RAMP_DIV   (RD),
        .DUTY_MAX   (DMAX),
        .DUTY_TURN  (DTURN),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .move_sig  (move_sig),
        .rotate_sig(rotate_sig),
        .left_dir  (left_dir),
        .left_pwm  (left_pwm),
        .right_dir (right_dir),
        .right_pwm (right_pwm),
        .settled   (settled)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model of the drive, stepped once per rising edge
    // ------------------------------------------------------------------
    logic       m_en;
    logic [1:0] m_mv, m_rt;
    int         m_pre, m_cnt;
    int         m_act[2], m_duty[2], m_dcnt[2];
    logic       m_dir[2], m_dead[2];
    logic       m_set;

    task automatic model_reset();
        m_en = 1'b0; m_mv = 2'b00; m_rt = 2'b00;
        m_pre = 0; m_cnt = 0; m_set = 1'b1;
        for (int w = 0; w < 2; w++) begin
            m_act[w] = 0; m_duty[w] = 0; m_dcnt[w] = 0;
            m_dir[w] = 1'b1; m_dead[w] = 1'b0;
        end
    endtask

    task automatic model_step();
        int   td[2];
        logic want[2];
        logic tdir[2];
        logic f, b, l, r, tick, all_ok;
        f = (m_mv == 2'b10); b = (m_mv == 2'b01);
        l = (m_rt == 2'b10); r = (m_rt == 2'b01);
        td = '{0, 0};
        want[0] = m_dir[0]; want[1] = m_dir[1];
        if (m_en) begin
            if (f && l)      begin td = '{DTURN, DMAX};  want = '{1'b1, 1'b1}; end
            else if (f && r) begin td = '{DMAX, DTURN};  want = '{1'b1, 1'b1}; end
            else if (f)      begin td = '{DMAX, DMAX};   want = '{1'b1, 1'b1}; end
            else if (b && l) begin td = '{DTURN, DMAX};  want = '{1'b0, 1'b0}; end
            else if (b && r) begin td = '{DMAX, DTURN};  want = '{1'b0, 1'b0}; end
            else if (b)      begin td = '{DMAX, DMAX};   want = '{1'b0, 1'b0}; end
            else if (l)      begin td = '{DTURN, DTURN}; want = '{1'b0, 1'b1}; end
            else if (r)      begin td = '{DTURN, DTURN}; want = '{1'b1, 1'b0}; end
        end
        for (int w = 0; w < 2; w++) tdir[w] = (td[w] == 0) ? m_dir[w] : want[w];
        tick = (m_pre == RD - 1);
        all_ok = 1'b1;
        for (int w = 0; w < 2; w++)
            if (m_dead[w] || m_duty[w] != td[w] || m_dir[w] != tdir[w]) all_ok = 1'b0;
        if (m_cnt == PER - 1)
            for (int w = 0; w < 2; w++) m_act[w] = m_duty[w];
        for (int w = 0; w < 2; w++) begin
            if (m_dead[w]) begin
                if (m_dcnt[w] == 0) begin
                    m_dead[w] = 1'b0;
                    m_dir[w]  = tdir[w];
                end else begin
                    m_dcnt[w]--;
                end
            end else if (tdir[w] == m_dir[w]) begin
                if (tick && m_duty[w] < td[w]) m_duty[w]++;
                else if (tick && m_duty[w] > td[w]) m_duty[w]--;
            end else if (m_duty[w] > 0) begin
                if (tick) m_duty[w]--;
            end else begin
                m_dead[w] = 1'b1;
                m_dcnt[w] = DC - 1;
            end
        end
        m_cnt = (m_cnt + 1) % PER;
        m_pre = (m_pre + 1) % RD;
        m_en  = enable; m_mv = move_sig; m_rt = rotate_sig;
        m_set = all_ok;
    endtask

    function automatic logic [4:0] model_obs();
        logic p0, p1;
        p0 = !m_dead[0] && (m_cnt < m_act[0]);
        p1 = !m_dead[1] && (m_cnt < m_act[1]);
        return {m_dir[0], p0, m_dir[1], p1, m_set};
    endfunction

    // Per-cycle scoreboard: expectation pushed at the edge, compared 1 time unit later.
    logic [4:0] sb_q[$];

    task automatic step();
        logic [4:0] exp_o;
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        sb_q.push_back(model_obs());
        #1;
        exp_o = sb_q.pop_front();
        check("cycle_outputs", int'({left_dir, left_pwm, right_dir, right_pwm, settled}),
              int'(exp_o));
    endtask

    task automatic measure(output int lh, output int rh);
        lh = 0; rh = 0;
        for (int i = 0; i < PER; i++) begin
            step();
            lh += int'(left_pwm);
            rh += int'(right_pwm);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] mv, input logic [1:0] rt);
        enable = en; move_sig = mv; rotate_sig = rt;
    endtask

    // ------------------------------------------------------------------
    // Table-driven vectors: steady-state result after holding each request
    // ------------------------------------------------------------------
    typedef struct {
        logic       en;
        logic [1:0] mv;
        logic [1:0] rt;
        int         hold;
        logic       ldir;
        logic       rdir;
        logic       set;
        int         lhigh;
        int         rhigh;
    } vec_t;

    vec_t vecs[13];
    vec_t exp_q[$];

    initial begin
        int   lh, rh, n, low_run, bad, unsettled;
        logic seen;
        vec_t v;

        vecs[0]  = '{1'b1, 2'b00, 2'b00, 50,  1'b1, 1'b1, 1'b1, 0,     0};
        vecs[1]  = '{1'b1, 2'b10, 2'b00, 60,  1'b1, 1'b1, 1'b1, DMAX,  DMAX};
        vecs[2]  = '{1'b1, 2'b01, 2'b00, 80,  1'b0, 1'b0, 1'b1, DMAX,  DMAX};
        vecs[3]  = '{1'b1, 2'b10, 2'b00, 80,  1'b1, 1'b1, 1'b1, DMAX,  DMAX};
        vecs[4]  = '{1'b1, 2'b11, 2'b00, 60,  1'b1, 1'b1, 1'b1, 0,     0};
        vecs[5]  = '{1'b1, 2'b00, 2'b10, 60,  1'b0, 1'b1, 1'b1, DTURN, DTURN};
        vecs[6]  = '{1'b1, 2'b10, 2'b10, 80,  1'b1, 1'b1, 1'b1, DTURN, DMAX};
        vecs[7]  = '{1'b1, 2'b10, 2'b01, 60,  1'b1, 1'b1, 1'b1, DMAX,  DTURN};
        vecs[8]  = '{1'b1, 2'b01, 2'b01, 100, 1'b0, 1'b0, 1'b1, DMAX,  DTURN};
        vecs[9]  = '{1'b1, 2'b01, 2'b10, 60,  1'b0, 1'b0, 1'b1, DTURN, DMAX};
        vecs[10] = '{1'b0, 2'b10, 2'b00, 60,  1'b0, 1'b0, 1'b1, 0,     0};
        vecs[11] = '{1'b1, 2'b00, 2'b01, 60,  1'b1, 1'b0, 1'b1, DTURN, DTURN};
        vecs[12] = '{1'b1, 2'b11, 2'b11, 60,  1'b1, 1'b0, 1'b1, 0,     0};

        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) step();
        check("reset_outputs", int'({left_dir, left_pwm, right_dir, right_pwm, settled}),
              int'(5'b10101));
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].en, vecs[i].mv, vecs[i].rt);
            exp_q.push_back(vecs[i]);
            repeat (vecs[i].hold) step();
            measure(lh, rh);
            v = exp_q.pop_front();
            check($sformatf("vec%0d_left_dir", i),  int'(left_dir),  int'(v.ldir));
            check($sformatf("vec%0d_right_dir", i), int'(right_dir), int'(v.rdir));
            check($sformatf("vec%0d_settled", i),   int'(settled),   int'(v.set));
            check($sformatf("vec%0d_left_high", i), lh, v.lhigh);
            check($sformatf("vec%0d_right_high", i), rh, v.rhigh);
        end

        // Forward at full duty, then reverse: ramp down, dead time, flip.
        drive(1'b1, 2'b10, 2'b00);
        repeat (60) step();
        check("fwd_settled", int'(settled), 1);
        drive(1'b1, 2'b01, 2'b00);
        n = 0; low_run = 0; seen = 1'b0;
        while (n < 200 && !seen) begin
            step();
            n++;
            if (!left_dir) seen = 1'b1;
            else if (!left_pwm) low_run++;
            else low_run = 0;
        end
        check("rev_flip_seen", int'(seen), 1);
        check("rev_flip_latency_ok", int'(n >= 28 && n <= 32), 1);
        check("rev_dead_low_run_ok", int'(low_run >= DC), 1);
        check("rev_settled_at_flip", int'(settled), 0);
        repeat (60) step();
        check("rev_final_dirs", int'({left_dir, right_dir}), 0);
        check("rev_final_settled", int'(settled), 1);

        // Conflicting move request from forward: ramp to stop, direction kept.
        drive(1'b1, 2'b10, 2'b00);
        repeat (80) step();
        drive(1'b1, 2'b11, 2'b00);
        bad = 0; unsettled = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!left_dir || !right_dir) bad++;
            if (!settled) unsettled++;
        end
        check("conflict_dir_changes", bad, 0);
        check("conflict_ramp_seen", int'(unsettled > 0), 1);
        check("conflict_final_settled", int'(settled), 1);

        // Rotate left from stop: only the left wheel owes a dead time.
        drive(1'b1, 2'b00, 2'b10);
        n = 0; seen = 1'b0; bad = 0;
        while (n < 30 && !seen) begin
            step();
            n++;
            if (!right_dir) bad++;
            if (!left_dir) seen = 1'b1;
        end
        check("rot_left_flip_latency", seen ? n : -1, 6);
        for (int i = 0; i < 60; i++) begin
            step();
            if (!right_dir) bad++;
        end
        check("rot_right_dir_held", bad, 0);
        measure(lh, rh);
        check("rot_left_high", lh, DTURN);
        check("rot_right_high", rh, DTURN);

        // Reset in the middle of a reverse ramp.
        rst_n = 1'b0;
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        drive(1'b1, 2'b01, 2'b00);
        repeat (20) step();
        check("pre_reset_left_dir", int'(left_dir), 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_outputs",
              int'({left_dir, left_pwm, right_dir, right_pwm, settled}), int'(5'b10101));
        step();
        drive(1'b1, 2'b00, 2'b00);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (left_pwm || right_pwm || !left_dir || !right_dir || !settled) bad++;
        end
        check("post_reset_idle", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
